// File: rtl/vga_rx_pkg.sv
// vga_dot_locator: raster geometry, lock states and colour helpers.
// Geometry is bundled in one struct so a whole raster can be swapped.
package vga_rx_pkg;

    localparam logic [9:0] H_TOTAL     = 10'd800;
    localparam logic [9:0] H_ACT_FIRST = 10'd145;
    localparam logic [9:0] H_ACT_LAST  = 10'd783;
    localparam logic [9:0] V_ACT_FIRST = 10'd36;
    localparam logic [9:0] V_ACT_LAST  = 10'd514;
    localparam logic [9:0] ORIGIN_X    = 10'd170;
    localparam logic [9:0] ORIGIN_Y    = 10'd141;

    typedef struct packed {
        logic [9:0] h_total;
        logic [9:0] h_act_first;
        logic [9:0] h_act_last;
        logic [9:0] v_act_first;
        logic [9:0] v_act_last;
        logic [9:0] origin_x;
        logic [9:0] origin_y;
    } geom_t;

    localparam geom_t GEOM_DEFAULT = '{
        h_total:     H_TOTAL,
        h_act_first: H_ACT_FIRST,
        h_act_last:  H_ACT_LAST,
        v_act_first: V_ACT_FIRST,
        v_act_last:  V_ACT_LAST,
        origin_x:    ORIGIN_X,
        origin_y:    ORIGIN_Y
    };

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        VERIFY,
        LOCKED
    } lock_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [7:0] RED_R = 8'hFF;
    localparam logic [7:0] RED_G = 8'h00;
    localparam logic [7:0] RED_B = 8'h00;

    function automatic logic is_red(rgb_t c);
        return (c.r == RED_R) && (c.g == RED_G) && (c.b == RED_B);
    endfunction

    function automatic logic [9:0] sat_inc(logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_dot_locator_if.sv
// vga_dot_locator: VGA sync and colour bundle.
// The generator side is master, the receiver side is slave.
interface vga_if;

    logic       VGA_HS;
    logic       VGA_VS;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        output VGA_HS, VGA_VS,
        output VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input VGA_HS, VGA_VS,
        input VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/vga_sync_tracker.sv
// vga_dot_locator: input registers, raster counters and lock FSM.
// Exports the registered pixel with its raster position.
module vga_sync_tracker
    import vga_rx_pkg::*;
#(
    parameter geom_t GEOM = GEOM_DEFAULT
) (
    input  logic        clk25MHz,
    input  logic        reset,
    vga_if.slave        vga,
    output rgb_t        pix,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        fe,
    output logic        fe_pub,
    output logic        locked,
    output logic        lock_lost,
    output logic [9:0]  frame_lines
);

    logic        s_hs, s_vs;
    logic        s_hs_d, s_vs_d;
    logic        hs_rise, vs_rise;
    logic        hs_exempt, h_err;
    logic [9:0]  count;
    logic [9:0]  cand, cand_n, lines_n;
    lock_state_t state, state_n;

    assign hs_rise = s_hs & ~s_hs_d;
    assign vs_rise = s_vs & ~s_vs_d;
    assign fe      = vs_rise;
    assign count   = rx_y + 10'd1;
    assign locked  = (state == LOCKED);

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            s_hs   <= 1'b0;
            s_vs   <= 1'b0;
            s_hs_d <= 1'b0;
            s_vs_d <= 1'b0;
            pix    <= '0;
            rx_x   <= '0;
            rx_y   <= '0;
        end else begin
            s_hs   <= vga.VGA_HS;
            s_vs   <= vga.VGA_VS;
            s_hs_d <= s_hs;
            s_vs_d <= s_vs;
            pix    <= '{r: vga.VGA_R, g: vga.VGA_G, b: vga.VGA_B};
            rx_x   <= hs_rise ? '0 : sat_inc(rx_x);
            if (hs_rise)
                rx_y <= vs_rise ? '0 : sat_inc(rx_y);
        end
    end

    // The first line after (re)entering MEASURE may start anywhere.
    assign h_err = (state != SEARCH) && (
        (hs_rise && (rx_x != GEOM.h_total - 10'd1) &&
         !(hs_exempt && state == MEASURE)) ||
        (!hs_rise && (rx_x == GEOM.h_total)));

    assign fe_pub = fe && (state == LOCKED) && (state_n == LOCKED);

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            state       <= SEARCH;
            cand        <= '0;
            frame_lines <= '0;
            lock_lost   <= 1'b0;
            hs_exempt   <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            frame_lines <= lines_n;
            lock_lost   <= (state == LOCKED) && (state_n == SEARCH);
            if (state_n == MEASURE && state != MEASURE)
                hs_exempt <= 1'b1;
            else if (hs_rise)
                hs_exempt <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        lines_n = frame_lines;
        unique case (state)
            SEARCH: begin
                if (fe)
                    state_n = MEASURE;
            end
            MEASURE: begin
                if (h_err) begin
                    state_n = SEARCH;
                end else if (fe) begin
                    cand_n  = count;
                    state_n = VERIFY;
                end
            end
            VERIFY: begin
                if (h_err) begin
                    state_n = SEARCH;
                end else if (fe && count == cand) begin
                    lines_n = cand;
                    state_n = LOCKED;
                end else if (fe) begin
                    cand_n  = count;
                    state_n = MEASURE;
                end
            end
            LOCKED: begin
                if (h_err || (fe && count != frame_lines))
                    state_n = SEARCH;
            end
        endcase
    end

endmodule

// File: rtl/vga_dot_locator.sv
// vga_dot_locator: locks to the VGA raster and reports the red dot
// position relative to the plot origin once per locked frame.
module vga_dot_locator
    import vga_rx_pkg::*;
#(
    parameter geom_t GEOM = GEOM_DEFAULT
) (
    input  logic        clk25MHz,
    input  logic        reset,
    vga_if.slave        vga,
    output logic        locked,
    output logic        lock_lost,
    output logic [9:0]  frame_lines,
    output logic        dot_valid,
    output logic        dot_found,
    output logic [8:0]  dot_x,
    output logic [8:0]  dot_y
);

    rgb_t       pix;
    logic [9:0] rx_x, rx_y;
    logic [9:0] dx, dy;
    logic       fe, fe_pub;
    logic       in_win, qual, off_ok;
    logic       cap_done, cap_ok;
    logic [8:0] cap_dx, cap_dy;

    vga_sync_tracker #(.GEOM(GEOM)) u_sync (
        .clk25MHz    (clk25MHz),
        .reset       (reset),
        .vga         (vga),
        .pix         (pix),
        .rx_x        (rx_x),
        .rx_y        (rx_y),
        .fe          (fe),
        .fe_pub      (fe_pub),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .frame_lines (frame_lines)
    );

    assign in_win = (rx_x >= GEOM.h_act_first) &&
                    (rx_x <= GEOM.h_act_last) &&
                    (rx_y >= GEOM.v_act_first) &&
                    (rx_y <= GEOM.v_act_last);
    assign qual   = is_red(pix) && in_win;

    // Offsets must be non-negative and fit in 9 bits.
    assign dx     = rx_x - GEOM.origin_x;
    assign dy     = rx_y - GEOM.origin_y;
    assign off_ok = (rx_x >= GEOM.origin_x) && !dx[9] &&
                    (rx_y >= GEOM.origin_y) && !dy[9];

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            dot_valid <= 1'b0;
            dot_found <= 1'b0;
            dot_x     <= '0;
            dot_y     <= '0;
            cap_done  <= 1'b0;
            cap_ok    <= 1'b0;
            cap_dx    <= '0;
            cap_dy    <= '0;
        end else begin
            dot_valid <= fe_pub;
            if (fe_pub) begin
                dot_found <= cap_ok;
                dot_x     <= cap_dx;
                dot_y     <= cap_dy;
            end
            if (fe) begin
                cap_done <= 1'b0;
                cap_ok   <= 1'b0;
                cap_dx   <= '0;
                cap_dy   <= '0;
            end else if (qual && !cap_done) begin
                cap_done <= 1'b1;
                cap_ok   <= off_ok;
                cap_dx   <= off_ok ? dx[8:0] : '0;
                cap_dy   <= off_ok ? dy[8:0] : '0;
            end
        end
    end

endmodule
